// File: rtl/fifo_pkt_pkg.sv
// ============================================================================
// Module   : fifo_pkt_pkg
// Purpose  : Shared types and constants for the FIFO packet writer.
//            The TRAIL state and the trailer word count depend on the
//            FIFO_PKT_WRITER_CSUM_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkt_pkg;

  // Packet writer FSM states; TRAIL exists only when the checksum is built in
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2
`ifdef FIFO_PKT_WRITER_CSUM_EN
    ,
    ST_TRAIL   = 2'd3
`endif
  } pkt_state_t;

  // Framing overhead around the payload, in FIFO words
  localparam int c_HDR_WORDS = 1;
`ifdef FIFO_PKT_WRITER_CSUM_EN
  localparam int c_TRL_WORDS = 1;
`else
  localparam int c_TRL_WORDS = 0;
`endif

endpackage

`default_nettype wire

// File: rtl/pkt_csum.sv
// ============================================================================
// Module   : pkt_csum
// Purpose  : Modulo-2**LOGIC_SIZE running sum of packet payload words.
//            Instantiated only when FIFO_PKT_WRITER_CSUM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pkt_csum #(
  parameter int LOGIC_SIZE = 8
) (
  input  logic                  i_wclk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic                  i_enable,
  input  logic [LOGIC_SIZE-1:0] i_data,
  output logic [LOGIC_SIZE-1:0] o_sum
);

  logic [LOGIC_SIZE-1:0] r_sum;

  // Accumulate accepted words; clear wins so a new packet starts from zero
  always_ff @(posedge i_wclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sum <= '0;
    end else if (i_clear) begin
      r_sum <= '0;
    end else if (i_enable) begin
      r_sum <= r_sum + i_data;
    end
  end

  assign o_sum = r_sum;

endmodule

`default_nettype wire

// File: rtl/fifo_pkt_writer.sv
// ============================================================================
// Module   : fifo_pkt_writer
// Purpose  : Frames an upstream word stream into FIFO packets: a length
//            header, the payload passed through combinationally and, when
//            FIFO_PKT_WRITER_CSUM_EN is defined, a checksum trailer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_pkt_writer
  import fifo_pkt_pkg::*;
#(
  parameter int LOGIC_SIZE = 8,
  parameter int MAX_LEN    = 16
) (
  input  logic                           i_wclk,
  input  logic                           i_rst_n,
  input  logic                           i_start,
  input  logic [$clog2(MAX_LEN+1)-1:0]   i_len,
  input  logic                           i_valid,
  input  logic [LOGIC_SIZE-1:0]          i_data,
  output logic                           o_ready,
  input  logic                           i_wfull,
  output logic                           o_wr,
  output logic [LOGIC_SIZE-1:0]          o_wdata,
  output logic                           o_busy,
  output logic                           o_done
);

  localparam int                LEN_W     = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0]  c_MAX_LEN = LEN_W'(MAX_LEN);

  pkt_state_t       r_state;
  pkt_state_t       w_state_nxt;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] w_cnt_inc;
  logic             r_done;
  logic             w_start;
  logic             w_accept;
  logic             w_last_wr;

  assign w_start   = (r_state == ST_IDLE) && i_start;
  assign w_accept  = (r_state == ST_PAYLOAD) && i_valid && !i_wfull;
  assign w_cnt_inc = r_cnt + LEN_W'(1);

`ifdef FIFO_PKT_WRITER_CSUM_EN
  logic [LOGIC_SIZE-1:0] w_sum;

  pkt_csum #(
    .LOGIC_SIZE (LOGIC_SIZE)
  ) u_pkt_csum (
    .i_wclk   (i_wclk),
    .i_rst_n  (i_rst_n),
    .i_clear  (w_start),
    .i_enable (w_accept),
    .i_data   (i_data),
    .o_sum    (w_sum)
  );
`endif

  // State register
  always_ff @(posedge i_wclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latch the clamped length when a packet is accepted in IDLE
  always_ff @(posedge i_wclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_len <= '0;
    end else if (w_start) begin
      r_len <= (i_len > c_MAX_LEN) ? c_MAX_LEN : i_len;
    end
  end

  // Payload word counter, held at zero between packets so it never wraps
  always_ff @(posedge i_wclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= w_cnt_inc;
    end
  end

  // Done pulses the cycle after the final word of a packet is written
  always_ff @(posedge i_wclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_last_wr;
    end
  end

  // Next-state and FIFO/upstream handshake decode
  always_comb begin
    w_state_nxt = r_state;
    o_wr        = 1'b0;
    o_wdata     = '0;
    o_ready     = 1'b0;
    w_last_wr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_HDR;
        end
      end
      ST_HDR: begin
        o_wr    = !i_wfull;
        o_wdata = LOGIC_SIZE'(r_len);
        if (!i_wfull) begin
          if (r_len == '0) begin
`ifdef FIFO_PKT_WRITER_CSUM_EN
            w_state_nxt = ST_TRAIL;
`else
            w_state_nxt = ST_IDLE;
            w_last_wr   = 1'b1;
`endif
          end else begin
            w_state_nxt = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        o_ready = !i_wfull;
        o_wr    = w_accept;
        o_wdata = i_data;
        if (w_accept && (w_cnt_inc == r_len)) begin
`ifdef FIFO_PKT_WRITER_CSUM_EN
          w_state_nxt = ST_TRAIL;
`else
          w_state_nxt = ST_IDLE;
          w_last_wr   = 1'b1;
`endif
        end
      end
`ifdef FIFO_PKT_WRITER_CSUM_EN
      ST_TRAIL: begin
        o_wr    = !i_wfull;
        o_wdata = w_sum;
        if (!i_wfull) begin
          w_state_nxt = ST_IDLE;
          w_last_wr   = 1'b1;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign o_busy = (r_state != ST_IDLE);
  assign o_done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_fifo_pkt_writer.sv
// ============================================================================
// Module   : tb_fifo_pkt_writer
// Purpose  : Self-checking bench for fifo_pkt_writer. A packet-level model
//            queues the words each packet must produce; a compare process
//            checks every FIFO write and the done pulse each cycle.
//            Honours FIFO_PKT_WRITER_CSUM_EN for the trailer word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fifo_pkt_writer;

  localparam int LS = 8;
  localparam int ML = 16;
  localparam int LW = $clog2(ML + 1);
`ifdef FIFO_PKT_WRITER_CSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] len   = '0;
  logic          valid = 1'b0;
  logic [LS-1:0] data  = '0;
  logic          wfull = 1'b0;
  logic          ready;
  logic          wr;
  logic [LS-1:0] wdata;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  fifo_pkt_writer #(
    .LOGIC_SIZE (LS),
    .MAX_LEN    (ML)
  ) dut (
    .i_wclk  (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_len   (len),
    .i_valid (valid),
    .i_data  (data),
    .o_ready (ready),
    .i_wfull (wfull),
    .o_wr    (wr),
    .o_wdata (wdata),
    .o_busy  (busy),
    .o_done  (done)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_w[$];
  bit         exp_last[$];
  logic [7:0] wr_log[$];
  int         wr_cyc[$];
  int         cyc = 0;
  bit         exp_done = 1'b0;
  bit         ready_seen = 1'b0;
  logic [7:0] pay[32];

  function automatic void check(input bit ok, input string name,
                                input longint act, input longint req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  // Model: a packet is header(clamped len), payload words, optional sum
  task automatic expect_pkt(input int l, input int base);
    int         n;
    logic [7:0] s;
    n = (l > ML) ? ML : l;
    s = 8'h00;
    exp_w.push_back(8'(n));
    exp_last.push_back(n == 0 && CS == 0);
    for (int i = 0; i < n; i++) begin
      exp_w.push_back(pay[base + i]);
      exp_last.push_back(i == n - 1 && CS == 0);
      s = s + pay[base + i];
    end
    if (CS != 0) begin
      exp_w.push_back(s);
      exp_last.push_back(1'b1);
    end
  endtask

  // Compare process: every write against the model, done every cycle
  always @(negedge clk) begin
    logic [7:0] w;
    bit         l;
    cyc++;
    if (!rst_n) begin
      exp_done = 1'b0;
    end else begin
      check(done == exp_done, "o_done", longint'(done), longint'(exp_done));
      exp_done = 1'b0;
      if (wfull) check(!wr && !ready, "wfull_block", longint'({wr, ready}), 0);
      if (ready) begin
        ready_seen = 1'b1;
        check(busy, "ready_busy", longint'(busy), 1);
      end
      if (wr) begin
        wr_log.push_back(wdata);
        wr_cyc.push_back(cyc);
        if (exp_w.size() == 0) begin
          check(1'b0, "unexpected_wr", longint'(wdata), -1);
        end else begin
          w = exp_w.pop_front();
          l = exp_last.pop_front();
          check(wdata == w, "wdata", longint'(wdata), longint'(w));
          exp_done = l;
        end
      end
    end
  end

  // Drive one packet: start pulse, upstream source, optional wfull window
  task automatic run_pkt(input int l, input int wf_start, input int wf_len);
    int n;
    int idx;
    int t;
    bit acc;
    n   = (l > ML) ? ML : l;
    idx = 0;
    t   = 0;
    while (busy && t < 200) begin
      @(posedge clk); #1; t++;
    end
    expect_pkt(l, 0);
    start = 1'b1;
    len   = LW'(l);
    t     = 0;
    while (t < 300) begin
      valid = (idx < n);
      data  = (idx < n) ? pay[idx] : 8'h00;
      wfull = (t >= wf_start) && (t < wf_start + wf_len);
      @(negedge clk);
      acc = valid && ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (acc) idx++;
      t++;
      if (idx == n && !busy) break;
    end
    check(t < 300, "pkt_timeout", t, 300);
    valid = 1'b0;
    wfull = 1'b0;
    @(posedge clk); #1;
    check(exp_w.size() == 0, "words_left", exp_w.size(), 0);
  endtask

  initial begin
    int         idx;
    int         t;
    int         ndone;
    bit         acc;
    bit         drop;
    logic [7:0] lit1[5];

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check(!busy && !wr && !ready && !done, "reset_outputs",
          longint'({busy, wr, ready, done}), 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Three-word packet with literal expectations
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    lit1 = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
    wr_log.delete();
    run_pkt(3, 1000, 0);
    check(wr_log.size() == 4 + CS, "p3_count", wr_log.size(), 4 + CS);
    for (int i = 0; i < wr_log.size() && i < 4 + CS; i++)
      check(wr_log[i] == lit1[i], "p3_literal", longint'(wr_log[i]), longint'(lit1[i]));

    // Zero-length packet
    wr_log.delete();
    ready_seen = 1'b0;
    run_pkt(0, 1000, 0);
    check(wr_log.size() == 1 + CS, "p0_count", wr_log.size(), 1 + CS);
    if (wr_log.size() > 0) check(wr_log[0] == 8'h00, "p0_header", longint'(wr_log[0]), 0);
    check(!ready_seen, "p0_ready", longint'(ready_seen), 0);

    // FIFO full for five cycles in the middle of the payload
    for (int i = 0; i < 6; i++) pay[i] = 8'(i * 13 + 5);
    wr_log.delete();
    run_pkt(6, 4, 5);
    check(wr_log.size() == 7 + CS, "pfull_count", wr_log.size(), 7 + CS);

    // Oversized length is clamped to MAX_LEN
    for (int i = 0; i < 20; i++) pay[i] = 8'(i * 3 + 1);
    wr_log.delete();
    run_pkt(20, 1000, 0);
    check(wr_log.size() == 17 + CS, "clamp_count", wr_log.size(), 17 + CS);
    if (wr_log.size() > 0) check(wr_log[0] == 8'h10, "clamp_header", longint'(wr_log[0]), 16);

    // Reset after two payload words abandons the packet
    for (int i = 0; i < 5; i++) pay[i] = 8'(8'hA0 + i);
    expect_pkt(5, 0);
    start = 1'b1;
    len   = LW'(5);
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0;
    t   = 0;
    while (idx < 2 && t < 50) begin
      valid = 1'b1;
      data  = pay[idx];
      @(negedge clk);
      acc = valid && ready;
      @(posedge clk); #1;
      if (acc) idx++;
      t++;
    end
    check(idx == 2, "rst_feed", idx, 2);
    #2 rst_n = 1'b0;
    #1;
    check(!wr, "rst_wr", longint'(wr), 0);
    check(!busy, "rst_busy", longint'(busy), 0);
    check(!ready && !done, "rst_ready_done", longint'({ready, done}), 0);
    exp_w.delete();
    exp_last.delete();
    valid = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h04;
    wr_log.delete();
    run_pkt(3, 1000, 0);
    if (wr_log.size() > 0) check(wr_log[0] == 8'h03, "post_rst_header", longint'(wr_log[0]), 3);
    check(wr_log.size() == 4 + CS, "post_rst_count", wr_log.size(), 4 + CS);

    // Back-to-back packets with i_start held across o_done
    pay[0] = 8'h10; pay[1] = 8'h20; pay[2] = 8'h30; pay[3] = 8'h40;
    wr_log.delete();
    wr_cyc.delete();
    expect_pkt(2, 0);
    expect_pkt(2, 2);
    start = 1'b1;
    len   = LW'(2);
    idx   = 0;
    t     = 0;
    ndone = 0;
    drop  = 1'b0;
    while (t < 300) begin
      valid = (idx < 4);
      data  = (idx < 4) ? pay[idx] : 8'h00;
      @(negedge clk);
      acc = valid && ready;
      @(posedge clk); #1;
      if (acc) idx++;
      if (drop) start = 1'b0;
      if (done) begin
        ndone++;
        if (ndone == 1) drop = 1'b1;
      end
      t++;
      if (idx == 4 && !busy && t > 3) break;
    end
    check(t < 300, "b2b_timeout", t, 300);
    start = 1'b0;
    valid = 1'b0;
    @(posedge clk); #1;
    check(exp_w.size() == 0, "b2b_words_left", exp_w.size(), 0);
    check(wr_cyc.size() == 6 + 2 * CS, "b2b_count", wr_cyc.size(), 6 + 2 * CS);
    if (wr_cyc.size() >= 4 + 2 * CS)
      check(wr_cyc[3 + CS] - wr_cyc[2 + CS] == 2, "b2b_gap",
            wr_cyc[3 + CS] - wr_cyc[2 + CS], 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
